key_input_ctrl: RTL
===================

KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on enter and entrada (minimum 2).
REQ-003 clk_kit  input  1  SHALL be the single clock, 50 MHz board clock; all state on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 enter  input  1  SHALL be the raw pushbutton, active-low (pressed = 0), asynchronous to clk_kit.
REQ-006 entrada  input  16  SHALL be the raw slide-switch word, asynchronous to clk_kit.
REQ-007 read_req  input  1  SHALL be the CPU's level request for one input word (ready).
REQ-008 data_out  output  16  SHALL be the captured switch word.
REQ-009 data_valid  output  1  SHALL mark data_out as valid for transfer.
REQ-010 armed  output  1  SHALL be high while waiting for a key press (LED indicator).
REQ-011 missed  output  1  SHALL be a sticky flag for a press made while not armed.

Function
REQ-012 enter and entrada SHALL each pass through a SYNC_STAGES flop chain before any other use.
REQ-013 The debouncer SHALL count cycles where synchronized enter differs from the debounced level, reset the count to 0 on any agreeing cycle, and toggle the debounced level on the cycle the count reaches DEBOUNCE_CYCLES.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; a release is the debounced 1 level.
REQ-015 FSM states SHALL be IDLE, ARMED, VALID and RELEASE.
REQ-016 IDLE: read_req=1 -> ARMED next cycle; armed=1 exactly in ARMED.
REQ-017 ARMED: press event -> latch synchronized entrada of that cycle into data_out, go to VALID; data_valid=1 from the next cycle.
REQ-018 ARMED: read_req=0 without a press -> IDLE (request aborted, nothing captured).
REQ-019 VALID: transfer on any edge with data_valid=1 and read_req=1; data_valid SHALL fall on the following cycle, go to RELEASE; data_out and data_valid hold otherwise.
REQ-020 RELEASE: wait for debounced release, then go to IDLE; a held key SHALL never produce a second capture.
REQ-021 A press event in IDLE or RELEASE SHALL set missed and be discarded, with no queueing.
REQ-022 missed SHALL clear on the cycle of the next capture in ARMED.
REQ-023 data_out SHALL keep its last value after transfer until the next capture.
REQ-024 Capture latency: data_valid SHALL rise SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after a stable raw enter fall, +/-1 cycle.

Reset
REQ-025 On reset_n=0, immediately: FSM = IDLE; data_out=0; data_valid=0; armed=0; missed=0; debounce count=0; debounced level=1; enter synchronizer=1; entrada synchronizer=0.
REQ-026 Reset mid-operation SHALL abandon any capture; after release, a key held low SHALL pass DEBOUNCE_CYCLES before a press event can occur.

Structure
REQ-027 FSM state encoding and default parameter constants SHALL live in a shared package, cpu_io_pkg.
REQ-028 Synchronizer plus debounce counter SHALL be one sub-module, key_debounce, outputting the level and the press pulse.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-029 Bench: read_req=1, entrada=16'hA5C3, enter low for 10 cycles -> one data_valid, data_out=16'hA5C3, armed falls at capture, missed=0.
REQ-030 Bench: bounce enter 1/0 every 2 cycles for 20 cycles, then hold low -> exactly one capture, no capture during bouncing.
REQ-031 Bench: press with read_req=0 -> missed=1, no data_valid; next armed press with entrada=16'h0001 -> data_out=16'h0001, missed=0.
REQ-032 Bench: read_req rises 5 cycles after data_valid -> data_valid holds, transfer then data_valid low next cycle; key held 50 cycles -> no second capture.
REQ-033 Bench: reset_n pulsed low while in VALID -> data_out=0, data_valid=0, FSM in IDLE within the same cycle.
REQ-034 Bench: read_req dropped while ARMED, then press -> return to IDLE, missed=1, data_out unchanged.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU input-port blocks: default timing constants,
// the data width and the key-capture state encoding.
package cpu_io_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int unsigned DEF_SYNC_STAGES     = 32'd2;
  localparam int unsigned DATA_W              = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_VALID   = 2'd2,
    ST_RELEASE = 2'd3
  } key_state_e;

  // Counter width able to hold the values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n < 32'd2) ? 32'd1 : $clog2(n + 32'd1);
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: synchronizer chain plus debounce counter, giving the
// stable key level and a one-cycle pulse on each debounced 1->0 change.
module key_debounce
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic                   level_q;
  logic                   level_d;
  logic                   press_q;
  logic                   press_d;
  logic                   key_s;
  logic                   differ_s;

  assign key_s    = sync_q[SYNC_STAGES-1];
  assign differ_s = key_s ^ level_q;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_raw_i};
    count_d = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (differ_s) begin
      if (count_q == CNT_LAST) begin
        level_d = key_s;
        press_d = ~key_s;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      count_q <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Key-driven input port: on a CPU request, waits for a debounced key press and
// captures the slide-switch word, handing it over with a valid/ready exchange.
module key_input_ctrl
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic              clk_kit,
  input  logic              reset_n,
  input  logic              enter,
  input  logic [DATA_W-1:0] entrada,
  input  logic              read_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              armed,
  output logic              missed
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] ent_sync_q;
  logic [DATA_W-1:0]                  ent_s;
  logic                               key_level_s;
  logic                               key_press_s;

  key_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              armed_q;
  logic              missed_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key (
    .clk_i    (clk_kit),
    .rst_ni   (reset_n),
    .key_raw_i(enter),
    .level_o  (key_level_s),
    .press_o  (key_press_s)
  );

  // The switch word is sampled through its own chain so capture sees a settled value.
  always_ff @(posedge clk_kit or negedge reset_n) begin
    if (!reset_n) begin
      ent_sync_q <= '0;
    end else begin
      ent_sync_q <= {ent_sync_q[SYNC_STAGES-2:0], entrada};
    end
  end

  assign ent_s = ent_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_kit or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      armed_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_press_s) begin
            missed_q <= 1'b1;
          end
          if (read_req) begin
            state_q <= ST_ARMED;
            armed_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (key_press_s) begin
            data_q   <= ent_s;
            valid_q  <= 1'b1;
            armed_q  <= 1'b0;
            missed_q <= 1'b0;
            state_q  <= ST_VALID;
          end else if (!read_req) begin
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_VALID: begin
          if (key_press_s) begin
            missed_q <= 1'b1;
          end
          if (valid_q && read_req) begin
            valid_q <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // A key still held here must come fully up before another capture.
          if (key_press_s) begin
            missed_q <= 1'b1;
          end
          if (key_level_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign armed      = armed_q;
  assign missed     = missed_q;

endmodule
